// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl
// Write-side (wclk) sequencer for the I2S transmit FIFO.
//  - Accepts L/R sample pairs from the host over s_valid/s_ready and writes each
//    pair to the FIFO as two words, left first, then right.
//  - Latches the stream configuration when a stream starts.
//  - Flushes the FIFO, prefills PREFILL words, then holds fifo_ren high until a
//    stop has drained the FIFO.
//  - Flags and counts underruns while streaming.
// Ports
//  wclk, rst                  clock, synchronous active-high reset
//  start, stop                stream control pulses
//  cfg_stereo/standard/word_size  configuration, latched on start
//  s_valid/s_ready/s_left/s_right host sample-pair handshake
//  fifo_full, fifo_empty      FIFO status
//  fifo_rst, fifo_wen, fifo_dinL, fifo_dinR, fifo_ren  FIFO control and data
//  stereo, standard, word_size latched configuration
//  busy                       high in every state except IDLE
//  underrun, underrun_clr, underrun_cnt  sticky underrun flag and event counter
module i2s_tx_ctrl #(
  parameter int PREFILL = 4,
  parameter int UCNT_W  = 8
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_stereo,
  input  logic [1:0]        cfg_standard,
  input  logic [1:0]        cfg_word_size,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_left,
  input  logic [31:0]       s_right,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_rst,
  output logic              fifo_wen,
  output logic [31:0]       fifo_dinL,
  output logic [31:0]       fifo_dinR,
  output logic              fifo_ren,
  output logic              stereo,
  output logic [1:0]        standard,
  output logic [1:0]        word_size,
  output logic              busy,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic [UCNT_W-1:0] underrun_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_PREFILL = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4
  } main_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_L    = 2'd1,
    W_R    = 2'd2
  } wr_state_t;

  localparam logic [3:0] PREFILL_C  = 4'(PREFILL);
  localparam logic [3:0] WR_CNT_MAX = 4'd8;

  main_state_t state_r, state_next_s;
  wr_state_t   w_state_r, w_next_s;
  logic [3:0]  wr_cnt_r, wr_cnt_next_s;
  logic        empty_d_r;
  logic        word_acc_s;
  logic        pair_hs_s;
  logic        unr_event_s;

  assign word_acc_s  = fifo_wen & ~fifo_full;
  assign pair_hs_s   = s_valid & s_ready;
  // Only a 0->1 edge of empty counts, so a FIFO that stays empty is one event.
  assign unr_event_s = (state_r == ST_RUN) & fifo_ren & fifo_empty & ~empty_d_r;

  // Written-word counter: cleared on flush, saturates at 8.
  always_comb begin
    wr_cnt_next_s = wr_cnt_r;
    if (state_r == ST_FLUSH) begin
      wr_cnt_next_s = 4'd0;
    end else if (word_acc_s && (wr_cnt_r < WR_CNT_MAX)) begin
      wr_cnt_next_s = wr_cnt_r + 4'd1;
    end else begin
      wr_cnt_next_s = wr_cnt_r;
    end
  end

  // Write FSM next state: a full FIFO simply holds the current word.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (pair_hs_s) w_next_s = W_L;
        else           w_next_s = W_IDLE;
      end
      W_L: begin
        if (!fifo_full) w_next_s = W_R;
        else            w_next_s = W_L;
      end
      W_R: begin
        if (!fifo_full) w_next_s = W_IDLE;
        else            w_next_s = W_R;
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Main FSM next state. Prefill completion looks at the post-increment count so
  // fifo_ren rises the cycle right after the last prefill word is accepted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) state_next_s = ST_FLUSH;
        else                state_next_s = ST_IDLE;
      end
      ST_FLUSH: state_next_s = ST_PREFILL;
      ST_PREFILL: begin
        if (stop)                              state_next_s = ST_DRAIN;
        else if (wr_cnt_next_s >= PREFILL_C)   state_next_s = ST_RUN;
        else                                   state_next_s = ST_PREFILL;
      end
      ST_RUN: begin
        if (stop) state_next_s = ST_DRAIN;
        else      state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        // The in-flight pair must finish before the drain can complete.
        if ((w_state_r == W_IDLE) && fifo_empty) state_next_s = ST_IDLE;
        else                                     state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State registers and state-derived outputs, computed from next state so they
  // line up with the state they describe.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      w_state_r <= W_IDLE;
      wr_cnt_r  <= 4'd0;
      fifo_rst  <= 1'b1;
      fifo_wen  <= 1'b0;
      s_ready   <= 1'b0;
      fifo_ren  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      w_state_r <= w_next_s;
      wr_cnt_r  <= wr_cnt_next_s;
      fifo_rst  <= (state_next_s == ST_FLUSH);
      fifo_wen  <= (w_next_s != W_IDLE);
      s_ready   <= (w_next_s == W_IDLE) &&
                   ((state_next_s == ST_PREFILL) || (state_next_s == ST_RUN));
      fifo_ren  <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
      busy      <= (state_next_s != ST_IDLE);
    end
  end

  // Stream configuration, captured only on the IDLE->FLUSH transition.
  always_ff @(posedge wclk) begin
    if (rst) begin
      stereo    <= 1'b0;
      standard  <= 2'b00;
      word_size <= 2'b00;
    end else if ((state_r == ST_IDLE) && start && !stop) begin
      stereo    <= cfg_stereo;
      standard  <= cfg_standard;
      word_size <= cfg_word_size;
    end else begin
      stereo    <= stereo;
      standard  <= standard;
      word_size <= word_size;
    end
  end

  // Sample pair capture; mono streams duplicate the left sample.
  always_ff @(posedge wclk) begin
    if (rst) begin
      fifo_dinL <= 32'd0;
      fifo_dinR <= 32'd0;
    end else if (pair_hs_s) begin
      fifo_dinL <= s_left;
      fifo_dinR <= stereo ? s_right : s_left;
    end else begin
      fifo_dinL <= fifo_dinL;
      fifo_dinR <= fifo_dinR;
    end
  end

  // Underrun flag and saturating counter; a clear outranks a same-cycle event.
  always_ff @(posedge wclk) begin
    if (rst) begin
      empty_d_r    <= 1'b1;
      underrun     <= 1'b0;
      underrun_cnt <= {UCNT_W{1'b0}};
    end else begin
      empty_d_r <= fifo_empty;
      if (underrun_clr) begin
        underrun     <= 1'b0;
        underrun_cnt <= {UCNT_W{1'b0}};
      end else if (unr_event_s) begin
        underrun <= 1'b1;
        if (!(&underrun_cnt)) underrun_cnt <= underrun_cnt + {{(UCNT_W-1){1'b0}}, 1'b1};
        else                  underrun_cnt <= underrun_cnt;
      end else begin
        underrun     <= underrun;
        underrun_cnt <= underrun_cnt;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Testbench for i2s_tx_ctrl: directed scenarios plus randomized streams, all
// outputs compared every cycle against a stream-level reference model.
module tb_i2s_tx_ctrl;

  localparam int PREFILL = 4;
  localparam int UCNT_W  = 8;
  localparam int UMAX    = 255;

  localparam int P_IDLE = 0, P_FLUSH = 1, P_PREFILL = 2, P_RUN = 3, P_DRAIN = 4;

  logic              wclk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, stop = 1'b0;
  logic              cfg_stereo = 1'b0;
  logic [1:0]        cfg_standard = 2'b00, cfg_word_size = 2'b00;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_left = 32'd0, s_right = 32'd0;
  logic              fifo_full = 1'b0, fifo_empty = 1'b0;
  logic              fifo_rst, fifo_wen, fifo_ren;
  logic [31:0]       fifo_dinL, fifo_dinR;
  logic              stereo, busy, underrun;
  logic [1:0]        standard, word_size;
  logic              underrun_clr = 1'b0;
  logic [UCNT_W-1:0] underrun_cnt;

  i2s_tx_ctrl #(.PREFILL(PREFILL), .UCNT_W(UCNT_W)) dut (
    .wclk(wclk), .rst(rst), .start(start), .stop(stop),
    .cfg_stereo(cfg_stereo), .cfg_standard(cfg_standard), .cfg_word_size(cfg_word_size),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rst(fifo_rst),
    .fifo_wen(fifo_wen), .fifo_dinL(fifo_dinL), .fifo_dinR(fifo_dinR),
    .fifo_ren(fifo_ren), .stereo(stereo), .standard(standard), .word_size(word_size),
    .busy(busy), .underrun(underrun), .underrun_clr(underrun_clr),
    .underrun_cnt(underrun_cnt)
  );

  always #5 wclk = ~wclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model (stream level) ----------------
  bit          m_valid = 1'b0;
  bit          m_in_rst = 1'b0;
  int          m_phase = P_IDLE;
  logic [31:0] pend[$];          // words of the current pair not yet taken by the FIFO
  int          m_written = 0;
  bit          m_stereo = 1'b0;
  logic [1:0]  m_std = 2'b00, m_ws = 2'b00;
  logic [31:0] m_dl = 32'd0, m_dr = 32'd0;
  bit          m_unr = 1'b0;
  int          m_cnt = 0;
  bit          m_pe = 1'b1;

  always @(posedge wclk) begin
    bit pend_was_empty;
    bit ready_now;
    if (rst) begin
      m_valid = 1'b1; m_in_rst = 1'b1; m_phase = P_IDLE; pend.delete();
      m_written = 0; m_stereo = 1'b0; m_std = 2'b00; m_ws = 2'b00;
      m_dl = 32'd0; m_dr = 32'd0; m_unr = 1'b0; m_cnt = 0; m_pe = 1'b1;
    end else begin
      m_in_rst = 1'b0;
      pend_was_empty = (pend.size() == 0);
      ready_now = pend_was_empty && (m_phase == P_PREFILL || m_phase == P_RUN);
      if (!pend_was_empty && !fifo_full) begin
        void'(pend.pop_front());
        if (m_written < 8) m_written++;
      end
      if (s_valid && ready_now) begin
        m_dl = s_left;
        m_dr = m_stereo ? s_right : s_left;
        pend.push_back(m_dl);
        pend.push_back(m_dr);
      end
      if (underrun_clr) begin
        m_unr = 1'b0; m_cnt = 0;
      end else if (m_phase == P_RUN && fifo_empty && !m_pe) begin
        m_unr = 1'b1;
        if (m_cnt < UMAX) m_cnt++;
      end
      m_pe = fifo_empty;
      case (m_phase)
        P_IDLE: if (start && !stop) begin
          m_stereo = cfg_stereo; m_std = cfg_standard; m_ws = cfg_word_size;
          m_phase = P_FLUSH;
        end
        P_FLUSH: begin m_written = 0; m_phase = P_PREFILL; end
        P_PREFILL: begin
          if (stop) m_phase = P_DRAIN;
          else if (m_written >= PREFILL) m_phase = P_RUN;
        end
        P_RUN: if (stop) m_phase = P_DRAIN;
        P_DRAIN: if (pend_was_empty && fifo_empty) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge wclk) begin
    if (m_valid) begin
      chk("fifo_rst", 32'(fifo_rst), 32'(m_in_rst || m_phase == P_FLUSH));
      chk("fifo_wen", 32'(fifo_wen), 32'(pend.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(pend.size() == 0 && (m_phase == P_PREFILL || m_phase == P_RUN)));
      chk("fifo_ren", 32'(fifo_ren), 32'(m_phase == P_RUN || m_phase == P_DRAIN));
      chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
      chk("underrun", 32'(underrun), 32'(m_unr));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
      chk("stereo", 32'(stereo), 32'(m_stereo));
      chk("standard", 32'(standard), 32'(m_std));
      chk("word_size", 32'(word_size), 32'(m_ws));
      chk("din_l", fifo_dinL, m_dl);
      chk("din_r", fifo_dinR, m_dr);
      if (pend.size() == 2) chk("word_l", fifo_dinL, pend[0]);
      else if (pend.size() == 1) chk("word_r", fifo_dinR, pend[0]);
    end
  end

  // ---------------- observed FIFO traffic ----------------
  logic [31:0] cap[$];
  bit  wsel = 1'b0;
  int  cyc_n = 0, acc4_cyc = -1, ren_rise_cyc = -1, rst_pulses = 0;
  logic ren_prev = 1'b1, rst_prev = 1'b1;

  always @(negedge wclk) begin
    cyc_n++;
    if (rst) wsel = 1'b0;
    else if (fifo_wen && !fifo_full) begin
      cap.push_back(wsel ? fifo_dinR : fifo_dinL);
      wsel = ~wsel;
      if (cap.size() == 4 && acc4_cyc < 0) acc4_cyc = cyc_n;
    end
    if (fifo_rst && !rst_prev) rst_pulses++;
    rst_prev = fifo_rst;
    if (fifo_ren && !ren_prev) ren_rise_cyc = cyc_n;
    ren_prev = fifo_ren;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic pulse_start(input logic st, input logic [1:0] sd, input logic [1:0] ws);
    cfg_stereo = st; cfg_standard = sd; cfg_word_size = ws;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
    int k = 0;
    s_left = l; s_right = r; s_valid = 1'b1;
    while (!s_ready && k < 60) begin tick(); k++; end
    chk("hs_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain_to_idle();
    int k = 0;
    s_valid = 1'b0; fifo_full = 1'b0; underrun_clr = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    fifo_empty = 1'b1;
    while (busy && k < 100) begin tick(); k++; end
    chk("drain_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a0, b0, a1, b1, c0, d0;
    int p0, n0;

    // T1: reset, stereo stream, two pairs fill the prefill
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    tick(); tick();
    chk("rst_fifo_rst", 32'(fifo_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    p0 = rst_pulses;
    pulse_start(1'b1, 2'b10, 2'b01);
    send_pair(a0, b0);
    send_pair(a1, b1);
    repeat (4) tick();
    chk("t1_words", 32'(cap.size()), 32'd4);
    if (cap.size() >= 4) begin
      chk("t1_w0", cap[0], a0); chk("t1_w1", cap[1], b0);
      chk("t1_w2", cap[2], a1); chk("t1_w3", cap[3], b1);
    end
    chk("t1_ren_lat", 32'(ren_rise_cyc - acc4_cyc), 32'd1);
    chk("t1_rst_pulse", 32'(rst_pulses - p0), 32'd1);
    chk("t1_ren", 32'(fifo_ren), 32'd1);

    // T2: full held while the right word is pending
    c0 = $urandom; d0 = $urandom;
    n0 = cap.size();
    send_pair(c0, d0);
    tick();
    fifo_full = 1'b1;
    repeat (5) begin
      tick();
      chk("t2_wen", 32'(fifo_wen), 32'd1);
      chk("t2_dinR", fifo_dinR, d0);
      chk("t2_ready", 32'(s_ready), 32'd0);
    end
    fifo_full = 1'b0;
    repeat (4) tick();
    chk("t2_count", 32'(cap.size() - n0), 32'd2);
    chk("t2_last", cap[$], d0);

    // T4: underrun events, clear, clear beats event
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    fifo_empty = 1'b1; tick();
    fifo_empty = 1'b0; tick();
    fifo_empty = 1'b1; tick();
    chk("t4_flag", 32'(underrun), 32'd1);
    chk("t4_cnt", 32'(underrun_cnt), 32'd2);
    fifo_empty = 1'b0;
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    chk("t4_clr_flag", 32'(underrun), 32'd0);
    chk("t4_clr_cnt", 32'(underrun_cnt), 32'd0);
    fifo_empty = 1'b1; underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    chk("t4_clr_wins", 32'(underrun_cnt), 32'd0);
    fifo_empty = 1'b0; tick();

    // T6a: start while running leaves latched config alone
    pulse_start(1'b0, 2'b01, 2'b00);
    tick();
    chk("t6_stereo", 32'(stereo), 32'd1);
    chk("t6_standard", 32'(standard), 32'd2);
    chk("t6_word_size", 32'(word_size), 32'd1);

    // T5: stop while the left word is pending
    n0 = cap.size();
    send_pair($urandom, $urandom);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t5_ready", 32'(s_ready), 32'd0);
    repeat (3) begin tick(); chk("t5_ren", 32'(fifo_ren), 32'd1); end
    chk("t5_pair", 32'(cap.size() - n0), 32'd2);
    fifo_empty = 1'b1; tick();
    chk("t5_ren_off", 32'(fifo_ren), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_no_unr", 32'(underrun_cnt), 32'd0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 32'd0);

    // T3: mono duplicates the left sample, then rst mid-run
    pulse_start(1'b0, 2'b00, 2'b00);
    fifo_empty = 1'b0;
    send_pair(32'h0000_1234, 32'h0000_FFFF);
    repeat (2) tick();
    chk("t3_l", cap[$-1], 32'h0000_1234);
    chk("t3_r", cap[$], 32'h0000_1234);
    send_pair($urandom, $urandom);
    repeat (3) tick();
    chk("t6_run", 32'(fifo_ren), 32'd1);
    rst = 1'b1; tick();
    chk("t6_rst_fifo_rst", 32'(fifo_rst), 32'd1);
    chk("t6_rst_ren", 32'(fifo_ren), 32'd0);
    chk("t6_rst_wen", 32'(fifo_wen), 32'd0);
    chk("t6_rst_dinL", fifo_dinL, 32'd0);
    rst = 1'b0; tick();

    // randomized streams
    for (int s = 0; s < 6; s++) begin
      pulse_start(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 300; i++) begin
        s_valid = 1'($urandom_range(0, 1));
        s_left = $urandom; s_right = $urandom;
        fifo_full = ($urandom_range(0, 3) == 0);
        fifo_empty = ($urandom_range(0, 7) == 0);
        underrun_clr = ($urandom_range(0, 31) == 0);
        stop = (i > 200) && ($urandom_range(0, 15) == 0);
        start = ($urandom_range(0, 63) == 0);
        cfg_stereo = 1'($urandom_range(0, 1));
        cfg_standard = 2'($urandom_range(0, 3));
        cfg_word_size = 2'($urandom_range(0, 3));
        tick();
      end
      start = 1'b0;
      drain_to_idle();
    end

    // counter saturation
    pulse_start(1'b1, 2'b00, 2'b00);
    fifo_empty = 1'b0;
    send_pair($urandom, $urandom);
    send_pair($urandom, $urandom);
    repeat (3) tick();
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fifo_empty = 1'b1; tick();
      fifo_empty = 1'b0; tick();
    end
    chk("sat_cnt", 32'(underrun_cnt), 32'd255);
    chk("sat_flag", 32'(underrun), 32'd1);
    drain_to_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
